music_player: RTL and testbench

- Sequencer that reads the song sheet ROM and plays it.
- Drives the sheet index `number`, then captures the returned note period, duration and done flag.
- Generates a square-wave speaker output at the note's frequency for the note's duration, with a short silent gap between notes.
- Sits between the board-level control (play/stop buttons) and the combinational sheet ROM; its output drives the audio pin.

---
 rtl/music_player.sv | 124 ++++++++++++
 tb/tb_music_player.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// Song sequencer: walks the sheet ROM by index, plays each note as a square wave
// for its duration, inserts a silent gap, and pulses finished at the end of the song.
module music_player #(
  parameter int TICK_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int LAST_INDEX  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic [19:0] note,
  input  logic [4:0]  duration,
  input  logic        done,
  output logic [9:0]  number,
  output logic        speaker,
  output logic        playing,
  output logic        finished
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FIN} state_t;

  localparam logic [22:0] TICK_LAST = 23'(TICK_CYCLES - 1);
  localparam logic [22:0] GAP_LAST  = (GAP_CYCLES == 0) ? 23'd0 : 23'(GAP_CYCLES - 1);
  localparam logic [9:0]  LAST_NUM  = 10'(LAST_INDEX);

  state_t      state;
  logic [19:0] note_r;
  logic [4:0]  dur_r;
  logic        last_r;
  logic [18:0] tone_cnt;
  logic [22:0] tick_cnt;
  logic [4:0]  unit_cnt;
  logic [22:0] gap_cnt;
  logic [18:0] half_last;
  logic        is_rest;

  assign half_last = note_r[19:1] - 19'd1;
  assign is_rest   = (note_r < 20'd2);
  assign playing   = (state == LOAD) || (state == PLAY) || (state == GAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      number   <= '0;
      speaker  <= 1'b0;
      finished <= 1'b0;
      note_r   <= '0;
      dur_r    <= '0;
      last_r   <= 1'b0;
      tone_cnt <= '0;
      tick_cnt <= '0;
      unit_cnt <= '0;
      gap_cnt  <= '0;
    end else if (stop && state != IDLE) begin
      // Abort wins over every other transition and never produces finished.
      state    <= IDLE;
      number   <= '0;
      speaker  <= 1'b0;
      finished <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          speaker <= 1'b0;
          number  <= '0;
          if (play) state <= LOAD;
        end
        LOAD: begin
          note_r   <= note;
          dur_r    <= (duration == 5'd0) ? 5'd1 : duration;
          last_r   <= done;
          tone_cnt <= '0;
          tick_cnt <= '0;
          unit_cnt <= '0;
          speaker  <= 1'b0;
          state    <= PLAY;
        end
        PLAY: begin
          if (is_rest) begin
            speaker <= 1'b0;
          end else if (tone_cnt == half_last) begin
            speaker  <= ~speaker;
            tone_cnt <= '0;
          end else begin
            tone_cnt <= tone_cnt + 19'd1;
          end
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + 5'd1;
            // Last cycle of the note: silence overrides any pending toggle.
            if (unit_cnt == dur_r - 5'd1) begin
              state   <= GAP;
              speaker <= 1'b0;
              gap_cnt <= '0;
            end
          end else begin
            tick_cnt <= tick_cnt + 23'd1;
          end
        end
        GAP: begin
          speaker <= 1'b0;
          if (gap_cnt >= GAP_LAST) begin
            if (last_r || number == LAST_NUM) begin
              state    <= FIN;
              finished <= 1'b1;
            end else begin
              number <= number + 10'd1;
              state  <= LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 23'd1;
          end
        end
        FIN: begin
          state  <= IDLE;
          number <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a short tick/gap so whole songs fit in a few hundred cycles.
module tb_music_player;

  logic        clk;
  logic        reset, play, stop;
  logic [19:0] note;
  logic [4:0]  duration;
  logic        done;
  logic [9:0]  number;
  logic        speaker, playing, finished;

  logic        reset2, play2, stop2;
  logic [19:0] note2;
  logic [4:0]  duration2;
  logic        done2;
  logic [9:0]  number2;
  logic        speaker2, playing2, finished2;

  int checks = 0;
  int errors = 0;
  int fin_seen = 0;
  int fin_before;

  music_player #(.TICK_CYCLES(10), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .play(play), .stop(stop),
    .note(note), .duration(duration), .done(done),
    .number(number), .speaker(speaker), .playing(playing), .finished(finished)
  );

  music_player #(.TICK_CYCLES(10), .GAP_CYCLES(2), .LAST_INDEX(3)) dut2 (
    .clk(clk), .reset(reset2), .play(play2), .stop(stop2),
    .note(note2), .duration(duration2), .done(done2),
    .number(number2), .speaker(speaker2), .playing(playing2), .finished(finished2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sheet model for the main instance
  always_comb begin
    note = 20'd0;
    duration = 5'd1;
    done = 1'b1;
    case (number)
      10'd0: begin note = 20'd8; duration = 5'd2; done = 1'b0; end
      10'd1: begin note = 20'd1; duration = 5'd1; done = 1'b0; end
      10'd2: begin note = 20'd4; duration = 5'd0; done = 1'b1; end
      default: ;
    endcase
  end

  // Sheet for the second instance never raises done
  assign note2 = 20'd6;
  assign duration2 = 5'd1;
  assign done2 = 1'b0;
  assign stop2 = 1'b0;

  always @(negedge clk) if (finished) fin_seen++;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; stop = 1'b0;
    reset2 = 1'b1; play2 = 1'b0;
    step(3);
    check("rst_number", number, 0);
    check("rst_speaker", speaker, 0);
    check("rst_playing", playing, 0);
    check("rst_finished", finished, 0);
    reset = 1'b0;
    step(2);
    check("idle_playing", playing, 0);

    // Scenario 1: index 0, note 8 (half 4), two units
    play = 1'b1;
    step(1);
    play = 1'b0;
    check("s1_load_playing", playing, 1);
    check("s1_load_number", number, 0);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check($sformatf("s1_spk_%0d", k), speaker, (k / 4) % 2);
    end
    for (int g = 0; g < 2; g++) begin
      step(1);
      check($sformatf("s1_gap_spk_%0d", g), speaker, 0);
      check($sformatf("s1_gap_num_%0d", g), number, 0);
    end
    step(1);
    check("s1_next_number", number, 1);
    check("s1_next_playing", playing, 1);

    // Scenario 2: index 1 is a rest
    for (int k = 0; k < 12; k++) begin
      step(1);
      check($sformatf("s2_rest_spk_%0d", k), speaker, 0);
      check($sformatf("s2_rest_play_%0d", k), playing, 1);
    end
    step(1);
    check("s2_next_number", number, 2);

    // Scenario 3: index 2, duration 0 treated as 1, half 2, then finish
    for (int k = 0; k < 10; k++) begin
      step(1);
      check($sformatf("s3_spk_%0d", k), speaker, (k / 2) % 2);
    end
    step(2);
    check("s3_gap_spk", speaker, 0);
    check("s3_gap_fin", finished, 0);
    step(1);
    check("s3_fin", finished, 1);
    check("s3_fin_number", number, 2);
    check("s3_fin_playing", playing, 0);
    step(1);
    check("s3_fin_width", finished, 0);
    check("s3_idle_number", number, 0);
    check("s3_idle_playing", playing, 0);
    check("s3_fin_count", fin_seen, 1);

    // Scenario 4: stop on PLAY cycle 7, then play+stop together
    fin_before = fin_seen;
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(8);
    check("s4_spk_before_stop", speaker, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("s4_stop_playing", playing, 0);
    check("s4_stop_speaker", speaker, 0);
    check("s4_stop_number", number, 0);
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(3);
    check("s4_in_play", playing, 1);
    play = 1'b1;
    stop = 1'b1;
    step(1);
    play = 1'b0;
    stop = 1'b0;
    check("s4_both_playing", playing, 0);
    step(2);
    check("s4_stays_idle", playing, 0);
    check("s4_no_finished", fin_seen, fin_before);

    // Scenario 5: async reset in the gap after index 1
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(34);
    check("s5_gap_number", number, 1);
    check("s5_gap_playing", playing, 1);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_playing", playing, 0);
    check("s5_async_number", number, 0);
    check("s5_async_speaker", speaker, 0);
    check("s5_async_finished", finished, 0);
    step(2);
    reset = 1'b0;
    step(1);
    play = 1'b1;
    step(1);
    play = 1'b0;
    check("s5_restart_playing", playing, 1);
    check("s5_restart_number", number, 0);
    step(5);
    check("s5_restart_spk", speaker, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("s5_no_finished", fin_seen, fin_before);

    // Scenario 6: LAST_INDEX=3, no done, play held high
    reset2 = 1'b0;
    step(1);
    play2 = 1'b1;
    step(1);
    for (int idx = 0; idx < 4; idx++) begin
      check($sformatf("s6_load_num_%0d", idx), number2, idx);
      check($sformatf("s6_load_play_%0d", idx), playing2, 1);
      check($sformatf("s6_load_fin_%0d", idx), finished2, 0);
      step(4);
      check($sformatf("s6_spk_%0d", idx), speaker2, 1);
      step(9);
    end
    check("s6_fin", finished2, 1);
    check("s6_fin_number", number2, 3);
    step(1);
    check("s6_idle_fin", finished2, 0);
    check("s6_idle_number", number2, 0);
    check("s6_idle_playing", playing2, 0);
    step(1);
    check("s6_replay_playing", playing2, 1);
    check("s6_replay_number", number2, 0);
    play2 = 1'b0;
    reset2 = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
